bmu_arbiter: RTL and testbench

Round-robin arbiter and issue sequencer that shares one bit-manipulation unit (BMU) among `NUM_REQ` requesters. Accepts operations over per-requester valid/ready handshakes, issues at most one operation per cycle to the BMU, and tracks ownership through the BMU's fixed pipeline latency. Routes `resultFf`/`error` back to the issuing requester. Provides a drain/halt state machine for scan mode and software-requested quiesce. Sits between execution-side requesters and the BMU instance.

---
 rtl/bmu_pkg.sv | 28 ++
 rtl/bmu_arbiter_if.sv | 41 ++++
 rtl/rr_arbiter.sv | 33 +++
 rtl/bmu_arbiter.sv | 152 +++++++++++++++
 tb/tb_bmu_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/bmu_pkg.sv
// Shared types and widths for the BMU arbiter slice: op encoding, FSM states,
// and the legality check applied to incoming operations.
package bmu_pkg;

  localparam int AP_W      = 5;
  localparam int DATA_W    = 32;
  localparam int ERR_CNT_W = 8;

  typedef struct packed {
    logic zbb;
    logic land;
    logic lxor;
    logic sll;
    logic sra;
  } ap_struct;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  // A CSR read is always legal; otherwise exactly one op bit must be set.
  function automatic logic ap_legal(input logic csr_ren, input logic [AP_W-1:0] ap);
    return csr_ren || ((ap != '0) && ((ap & (ap - AP_W'(1))) == '0));
  endfunction

endpackage

// File: rtl/bmu_arbiter_if.sv
// Requester handshakes and BMU issue/return bus shared by the arbiter and its environment.
interface bmu_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import bmu_pkg::*;

  logic [NUM_REQ-1:0]        reqValid;
  logic [NUM_REQ-1:0]        reqReady;
  logic [NUM_REQ*AP_W-1:0]   reqAp;
  logic [NUM_REQ-1:0]        reqCsrRen;
  logic [NUM_REQ*DATA_W-1:0] reqCsrRdata;
  logic [NUM_REQ*DATA_W-1:0] reqA;
  logic [NUM_REQ*DATA_W-1:0] reqB;

  logic [NUM_REQ-1:0]        rspValid;
  logic [DATA_W-1:0]         rspResult;
  logic                      rspError;

  logic                      bmuValidIn;
  logic [AP_W-1:0]           bmuAp;
  logic                      bmuCsrRenIn;
  logic [DATA_W-1:0]         bmuCsrRdataIn;
  logic [DATA_W-1:0]         bmuAIn;
  logic [DATA_W-1:0]         bmuBIn;
  logic                      bmuScanMode;
  logic [DATA_W-1:0]         bmuResultFf;
  logic                      bmuError;

  modport slave (
    input  reqValid, reqAp, reqCsrRen, reqCsrRdata, reqA, reqB, bmuResultFf, bmuError,
    output reqReady, rspValid, rspResult, rspError,
    output bmuValidIn, bmuAp, bmuCsrRenIn, bmuCsrRdataIn, bmuAIn, bmuBIn, bmuScanMode
  );

  modport master (
    output reqValid, reqAp, reqCsrRen, reqCsrRdata, reqA, reqB, bmuResultFf, bmuError,
    input  reqReady, rspValid, rspResult, rspError,
    input  bmuValidIn, bmuAp, bmuCsrRenIn, bmuCsrRdataIn, bmuAIn, bmuBIn, bmuScanMode
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first request at or after ptr wins, and
// next_ptr points just past the winner (or holds when nothing is granted).
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] next_ptr
);

  localparam int PW = $clog2(NUM_REQ);

  logic found;
  int   idx;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        next_ptr   = PW'((idx + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/bmu_arbiter.sv
// Shares one BMU among NUM_REQ requesters: round-robin issue, ownership tags
// through the BMU latency, response routing, and a drain/halt controller.
module bmu_arbiter
  import bmu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int BMU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rstL,
  input  logic                 scanMode,
  input  logic                 haltReq,
  output logic                 halted,
  output logic [ERR_CNT_W-1:0] errCount,
  bmu_arbiter_if.slave         bus
);

  localparam int PW    = $clog2(NUM_REQ);
  localparam int DEPTH = BMU_LAT + 1;
  localparam int CW    = $clog2(DEPTH + 1);

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     next_ptr;
  logic [PW-1:0]     sel_idx;
  logic [NUM_REQ-1:0] grant;
  logic              accept;
  logic              legal;
  logic              retire;
  ap_struct          sel_ap;
  logic              sel_csr_ren;
  logic [DATA_W-1:0] sel_csr_rdata;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [DEPTH-1:0]  tag_valid;
  logic [DEPTH-1:0]  tag_bypass;
  logic [PW-1:0]     tag_owner [DEPTH];
  logic [CW-1:0]     inflight;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req      (bus.reqValid),
    .ptr      (rr_ptr),
    .en       (state == RUN),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  assign bus.reqReady    = grant;
  assign accept          = |grant;
  assign bus.bmuScanMode = scanMode;

  always_comb begin
    sel_idx       = '0;
    sel_ap        = '0;
    sel_csr_ren   = 1'b0;
    sel_csr_rdata = '0;
    sel_a         = '0;
    sel_b         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_idx       = PW'(i);
        sel_ap        = bus.reqAp[i*AP_W +: AP_W];
        sel_csr_ren   = bus.reqCsrRen[i];
        sel_csr_rdata = bus.reqCsrRdata[i*DATA_W +: DATA_W];
        sel_a         = bus.reqA[i*DATA_W +: DATA_W];
        sel_b         = bus.reqB[i*DATA_W +: DATA_W];
      end
    end
  end

  assign legal  = ap_legal(sel_csr_ren, sel_ap);
  assign retire = tag_valid[DEPTH-1];

  // Illegal ops never reach the BMU, so their slot answers with a forced error.
  always_comb begin
    bus.rspValid = '0;
    if (retire) bus.rspValid[tag_owner[DEPTH-1]] = 1'b1;
    bus.rspResult = tag_bypass[DEPTH-1] ? '0 : bus.bmuResultFf;
    bus.rspError  = tag_bypass[DEPTH-1] ? 1'b1 : bus.bmuError;
  end

  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      bus.bmuValidIn    <= 1'b0;
      bus.bmuAp         <= '0;
      bus.bmuCsrRenIn   <= 1'b0;
      bus.bmuCsrRdataIn <= '0;
      bus.bmuAIn        <= '0;
      bus.bmuBIn        <= '0;
    end else begin
      bus.bmuValidIn <= accept && legal;
      if (accept && legal) begin
        bus.bmuAp         <= sel_ap;
        bus.bmuCsrRenIn   <= sel_csr_ren;
        bus.bmuCsrRdataIn <= sel_csr_rdata;
        bus.bmuAIn        <= sel_a;
        bus.bmuBIn        <= sel_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      rr_ptr     <= '0;
      tag_valid  <= '0;
      tag_bypass <= '0;
      for (int s = 0; s < DEPTH; s++) tag_owner[s] <= '0;
      inflight   <= '0;
      errCount   <= '0;
    end else begin
      if (accept) rr_ptr <= next_ptr;
      tag_valid    <= {tag_valid[DEPTH-2:0], accept};
      tag_bypass   <= {tag_bypass[DEPTH-2:0], accept && !legal};
      tag_owner[0] <= sel_idx;
      for (int s = 1; s < DEPTH; s++) tag_owner[s] <= tag_owner[s-1];
      inflight <= inflight + CW'(accept) - CW'(retire);
      if (retire && bus.rspError && (errCount != {ERR_CNT_W{1'b1}}))
        errCount <= errCount + 1'b1;
    end
  end

  // DRAIN waits for every accepted op to return before reporting halted.
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (haltReq || scanMode) state <= DRAIN;
        end
        DRAIN: begin
          if (inflight == '0) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          if (!haltReq && !scanMode) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bmu_arbiter.sv
// Directed bench for bmu_arbiter (NUM_REQ=2, BMU_LAT=1) with a one-cycle BMU model.
module tb_bmu_arbiter;

  localparam logic [4:0] LAND = 5'b01000;
  localparam logic [4:0] LXOR = 5'b00100;
  localparam logic [4:0] ILL  = 5'b00011;
  localparam int NV = 23;

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  ap0;
    logic [4:0]  ap1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] b;
    logic        halt;
    logic [1:0]  expReady;
    logic        expBmuV;
    logic [1:0]  expRsp;
    logic [31:0] expResult;
    logic        expErr;
    logic        expHalted;
  } vec_t;

  logic       clk;
  logic       rstL;
  logic       scanMode;
  logic       haltReq;
  logic       halted;
  logic [7:0] errCount;
  int         nCmp;
  int         nFail;
  vec_t       vecs [NV];

  bmu_arbiter_if #(.NUM_REQ(2)) bus ();

  bmu_arbiter #(.NUM_REQ(2), .BMU_LAT(1)) dut (
    .clk      (clk),
    .rstL     (rstL),
    .scanMode (scanMode),
    .haltReq  (haltReq),
    .halted   (halted),
    .errCount (errCount),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bmuModel(input logic [4:0] ap, input logic csr,
                                           input logic [31:0] rd, input logic [31:0] a,
                                           input logic [31:0] b);
    if (csr) return rd;
    case (ap)
      5'b10000: return ~a;
      5'b01000: return a & b;
      5'b00100: return a ^ b;
      5'b00010: return a << b[4:0];
      5'b00001: return $unsigned($signed(a) >>> b[4:0]);
      default:  return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rstL) begin
    if (!rstL) bus.bmuResultFf <= 32'h0;
    else if (bus.bmuValidIn)
      bus.bmuResultFf <= bmuModel(bus.bmuAp, bus.bmuCsrRenIn, bus.bmuCsrRdataIn, bus.bmuAIn, bus.bmuBIn);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.reqValid = v.valid;
    bus.reqAp    = {v.ap1, v.ap0};
    bus.reqA     = {v.a1, v.a0};
    bus.reqB     = {v.b, v.b};
    haltReq      = v.halt;
  endtask

  task automatic checkOutput(input int i, input vec_t v);
    chk($sformatf("vec%0d reqReady", i), 32'(bus.reqReady), 32'(v.expReady));
    chk($sformatf("vec%0d bmuValidIn", i), 32'(bus.bmuValidIn), 32'(v.expBmuV));
    chk($sformatf("vec%0d rspValid", i), 32'(bus.rspValid), 32'(v.expRsp));
    chk($sformatf("vec%0d halted", i), 32'(halted), 32'(v.expHalted));
    if (v.expRsp != 2'b00) begin
      chk($sformatf("vec%0d rspResult", i), bus.rspResult, v.expResult);
      chk($sformatf("vec%0d rspError", i), 32'(bus.rspError), 32'(v.expErr));
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nCmp = 0;
    nFail = 0;
    // valid ap0 ap1 a0 a1 b halt | ready bmuV rsp result err halted
    vecs[0]  = '{2'b01, LAND, 5'd0, 32'hF0F0F0F0, 32'h0, 32'hFF00FF00, 1'b0, 2'b01, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0};
    vecs[2]  = '{2'b10, 5'd0, LXOR, 32'h0, 32'h0000FFFF, 32'h0F0F0F0F, 1'b0, 2'b10, 1'b0, 2'b01, 32'hF000F000, 1'b0, 1'b0};
    vecs[3]  = '{2'b11, LAND, LAND, 32'h12345678, 32'h87654321, 32'hFFFF0000, 1'b0, 2'b01, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, LAND, LAND, 32'h12345678, 32'h87654321, 32'hFFFF0000, 1'b0, 2'b10, 1'b1, 2'b10, 32'h0F0FF0F0, 1'b0, 1'b0};
    vecs[5]  = '{2'b11, LAND, LAND, 32'h12345678, 32'h87654321, 32'h0000FFFF, 1'b0, 2'b01, 1'b1, 2'b01, 32'h12340000, 1'b0, 1'b0};
    vecs[6]  = '{2'b11, LAND, LAND, 32'h12345678, 32'h87654321, 32'h0000FFFF, 1'b0, 2'b10, 1'b1, 2'b10, 32'h87650000, 1'b0, 1'b0};
    vecs[7]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 2'b01, 32'h00005678, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 2'b10, 32'h00004321, 1'b0, 1'b0};
    vecs[9]  = '{2'b10, 5'd0, ILL, 32'h0, 32'hAAAA5555, 32'h0, 1'b0, 2'b10, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0};
    vecs[10] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0};
    vecs[11] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 2'b10, 32'h0, 1'b1, 1'b0};
    vecs[12] = '{2'b01, LAND, 5'd0, 32'h11111111, 32'h0, 32'hFFFFFFFF, 1'b0, 2'b01, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0};
    vecs[13] = '{2'b10, 5'd0, LAND, 32'h0, 32'h22222222, 32'hFFFFFFFF, 1'b0, 2'b10, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0};
    vecs[14] = '{2'b01, LAND, 5'd0, 32'h33333333, 32'h0, 32'hFFFFFFFF, 1'b0, 2'b01, 1'b1, 2'b01, 32'h11111111, 1'b0, 1'b0};
    vecs[15] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 2'b10, 32'h22222222, 1'b0, 1'b0};
    vecs[16] = '{2'b11, LAND, LAND, 32'h55555555, 32'h66666666, 32'hFFFFFFFF, 1'b1, 2'b00, 1'b0, 2'b01, 32'h33333333, 1'b0, 1'b0};
    vecs[17] = '{2'b11, LAND, LAND, 32'h55555555, 32'h66666666, 32'hFFFFFFFF, 1'b1, 2'b00, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0};
    vecs[18] = '{2'b11, LAND, LAND, 32'h55555555, 32'h66666666, 32'hFFFFFFFF, 1'b1, 2'b00, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1};
    vecs[19] = '{2'b11, LAND, LAND, 32'h55555555, 32'h66666666, 32'hFFFFFFFF, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1};
    vecs[20] = '{2'b10, 5'd0, LAND, 32'h0, 32'h44444444, 32'hFFFFFFFF, 1'b0, 2'b10, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0};
    vecs[21] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0};
    vecs[22] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 2'b10, 32'h44444444, 1'b0, 1'b0};

    rstL            = 1'b0;
    scanMode        = 1'b0;
    haltReq         = 1'b0;
    bus.reqValid    = '0;
    bus.reqAp       = '0;
    bus.reqCsrRen   = '0;
    bus.reqCsrRdata = '0;
    bus.reqA        = '0;
    bus.reqB        = '0;
    bus.bmuError    = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset bmuValidIn", 32'(bus.bmuValidIn), 32'h0);
    chk("reset bmuAp", 32'(bus.bmuAp), 32'h0);
    chk("reset bmuAIn", bus.bmuAIn, 32'h0);
    chk("reset halted", 32'(halted), 32'h0);
    chk("reset errCount", 32'(errCount), 32'h0);
    chk("reset rspValid", 32'(bus.rspValid), 32'h0);
    chk("reset reqReady", 32'(bus.reqReady), 32'h0);
    #2 rstL = 1'b1;
    nextCycle();

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(i, vecs[i]);
      nextCycle();
    end
    @(negedge clk);
    chk("errCount after illegal op", 32'(errCount), 32'd1);

    // Scan pulse while idle: one DRAIN cycle, one HALTED cycle, then RUN.
    nextCycle();
    scanMode = 1'b1;
    @(negedge clk);
    chk("scan bmuScanMode high", 32'(bus.bmuScanMode), 32'h1);
    chk("scan halted c0", 32'(halted), 32'h0);
    nextCycle();
    scanMode     = 1'b0;
    bus.reqValid = 2'b01;
    bus.reqAp    = {5'd0, LAND};
    @(negedge clk);
    chk("scan bmuScanMode low", 32'(bus.bmuScanMode), 32'h0);
    chk("scan drain reqReady", 32'(bus.reqReady), 32'h0);
    chk("scan drain halted", 32'(halted), 32'h0);
    nextCycle();
    @(negedge clk);
    chk("scan halted state", 32'(halted), 32'h1);
    chk("scan halted reqReady", 32'(bus.reqReady), 32'h0);
    nextCycle();
    @(negedge clk);
    chk("scan resumed halted", 32'(halted), 32'h0);
    chk("scan resumed reqReady", 32'(bus.reqReady), 32'h1);
    nextCycle();
    bus.reqValid = 2'b00;
    repeat (3) nextCycle();

    // Reset with two operations in flight.
    bus.reqValid = 2'b11;
    bus.reqAp    = {LAND, LAND};
    nextCycle();
    nextCycle();
    bus.reqValid = 2'b00;
    rstL = 1'b0;
    @(negedge clk);
    chk("midreset rspValid", 32'(bus.rspValid), 32'h0);
    chk("midreset bmuValidIn", 32'(bus.bmuValidIn), 32'h0);
    chk("midreset errCount", 32'(errCount), 32'h0);
    #2 rstL = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("postreset rspValid c%0d", c), 32'(bus.rspValid), 32'h0);
    end
    chk("postreset errCount", 32'(errCount), 32'h0);

    // 300 illegal ops must saturate the error counter.
    nextCycle();
    bus.reqValid = 2'b01;
    bus.reqAp    = {5'd0, 5'd0};
    repeat (300) nextCycle();
    bus.reqValid = 2'b00;
    repeat (3) nextCycle();
    @(negedge clk);
    chk("errCount saturated", 32'(errCount), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
